// File: rtl/csr_file_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// csr_file_pkg: CSR addresses, op codes, field positions and WARL masks.
// Rev 1.0
// ----------------------------------------------------------------------------
package csr_file_pkg;

  typedef enum logic [1:0] {
    CSR_OP_READ  = 2'b00,
    CSR_OP_WRITE = 2'b01,
    CSR_OP_SET   = 2'b10,
    CSR_OP_CLEAR = 2'b11
  } csr_op_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] MSR_MTAGS     = 12'h7C0;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIP_MSIP_BIT     = 3;
  localparam int MIP_MTIP_BIT     = 7;
  localparam int MIP_MEIP_BIT     = 11;

  localparam logic [31:0] MSTATUS_MPP_BITS = 32'h0000_1800;
  localparam logic [31:0] MIE_WMASK        = 32'h0000_0888;
  localparam logic [31:0] ALIGN_MASK       = 32'hFFFF_FFFC;

  // The whole 0xC00-0xFFF quadrant is read-only, plus misa.
  function automatic logic csr_is_ro(input logic [11:0] addr);
    return (addr[11:10] == 2'b11) || (addr == CSR_MISA);
  endfunction

endpackage
`default_nettype wire

// File: rtl/csr_counter64.sv
`default_nettype none
// ----------------------------------------------------------------------------
// csr_counter64: double-width counter; a half write overrides the increment.
// Rev 1.0
// ----------------------------------------------------------------------------
module csr_counter64 #(
  parameter int W = 32
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           inc_i,
  input  logic           wr_lo_i,
  input  logic           wr_hi_i,
  input  logic [W-1:0]   wdata_i,
  output logic [2*W-1:0] value_o
);

  logic [W-1:0] lo_q;
  logic [W-1:0] hi_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      lo_q <= '0;
      hi_q <= '0;
    end else if (wr_lo_i) begin
      lo_q <= wdata_i;
    end else if (wr_hi_i) begin
      hi_q <= wdata_i;
    end else if (inc_i) begin
      {hi_q, lo_q} <= {hi_q, lo_q} + (2*W)'(1);
    end
  end

  assign value_o = {hi_q, lo_q};

endmodule
`default_nettype wire

// File: rtl/csr_file.sv
`default_nettype none
// ----------------------------------------------------------------------------
// csr_file: machine-mode CSR unit, 2-cycle RMW access, trap/mret updates.
// Optional mcycle/minstret counters with macro CSR_COUNTERS_EN.  Rev 1.0
// ----------------------------------------------------------------------------
module csr_file
  import csr_file_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter logic [XLEN-1:0] HART_ID     = '0,
  parameter logic [XLEN-1:0] VENDOR_ID   = '0,
  parameter logic [XLEN-1:0] MISA_VALUE  = 32'h4000_0100,
  parameter logic [XLEN-1:0] MTVEC_RESET = 32'h0000_0100,
  parameter int              TAGS_WIDTH  = 8
) (
  input  logic            clk_i,
  input  logic            rst_n_i,
  input  logic            csr_en_i,
  input  logic [1:0]      csr_op_i,
  input  logic [11:0]     csr_addr_i,
  input  logic [XLEN-1:0] csr_data_i,
  output logic [XLEN-1:0] csr_data_o,
  output logic            csr_busy_o,
  output logic            csr_done_o,
  output logic            csr_exists_o,
  output logic            csr_ro_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_cause_i,
  input  logic [XLEN-1:0] trap_epc_i,
  input  logic [XLEN-1:0] trap_tval_i,
  input  logic            mret_i,
  input  logic            instret_i,
  input  logic            irq_ext_i,
  input  logic            irq_timer_i,
  output logic [XLEN-1:0] mtvec_o,
  output logic [XLEN-1:0] mepc_o,
  output logic            irq_pending_o
);

  logic                  busy_q, done_q, exists_q, ro_q;
  logic [XLEN-1:0]       rdata_q;
  csr_op_e               op_q;
  logic [11:0]           addr_q;
  logic [XLEN-1:0]       opnd_q;

  logic                  st_mie_q, st_mpie_q, msip_q;
  logic [XLEN-1:0]       mie_q, mtvec_q, mepc_q, mcause_q, mtval_q, mscratch_q;
  logic [TAGS_WIDTH-1:0] mtags_q;

  logic [XLEN-1:0]       old_d, new_d, mip_w, mstatus_w;
  logic                  exists_d, commit_d;

`ifdef CSR_COUNTERS_EN
  logic [2*XLEN-1:0]     mcycle_w, minstret_w;
`endif

  always_comb begin
    mip_w                   = '0;
    mip_w[MIP_MEIP_BIT]     = irq_ext_i;
    mip_w[MIP_MTIP_BIT]     = irq_timer_i;
    mip_w[MIP_MSIP_BIT]     = msip_q;
    mstatus_w               = MSTATUS_MPP_BITS;
    mstatus_w[MSTATUS_MIE_BIT]  = st_mie_q;
    mstatus_w[MSTATUS_MPIE_BIT] = st_mpie_q;
  end

  always_comb begin
    old_d    = '0;
    exists_d = 1'b1;
    case (addr_q)
      CSR_MSTATUS:   old_d = mstatus_w;
      CSR_MISA:      old_d = MISA_VALUE;
      CSR_MIE:       old_d = mie_q;
      CSR_MTVEC:     old_d = mtvec_q;
      CSR_MSCRATCH:  old_d = mscratch_q;
      CSR_MEPC:      old_d = mepc_q;
      CSR_MCAUSE:    old_d = mcause_q;
      CSR_MTVAL:     old_d = mtval_q;
      CSR_MIP:       old_d = mip_w;
      CSR_MVENDORID: old_d = VENDOR_ID;
      CSR_MHARTID:   old_d = HART_ID;
      MSR_MTAGS:     old_d[TAGS_WIDTH-1:0] = mtags_q;
`ifdef CSR_COUNTERS_EN
      CSR_MCYCLE,   CSR_CYCLE:    old_d = mcycle_w[XLEN-1:0];
      CSR_MCYCLEH,  CSR_CYCLEH:   old_d = mcycle_w[2*XLEN-1:XLEN];
      CSR_MINSTRET, CSR_INSTRET:  old_d = minstret_w[XLEN-1:0];
      CSR_MINSTRETH, CSR_INSTRETH: old_d = minstret_w[2*XLEN-1:XLEN];
`endif
      default:       exists_d = 1'b0;
    endcase
  end

  always_comb begin
    case (op_q)
      CSR_OP_WRITE: new_d = opnd_q;
      CSR_OP_SET:   new_d = old_d | opnd_q;
      CSR_OP_CLEAR: new_d = old_d & ~opnd_q;
      default:      new_d = old_d;
    endcase
  end

  // Reads never commit, so a plain read of a counter cannot stall its increment.
  assign commit_d = busy_q && exists_d && !csr_is_ro(addr_q) && (op_q != CSR_OP_READ);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      exists_q <= 1'b0;
      ro_q     <= 1'b0;
      rdata_q  <= '0;
      op_q     <= CSR_OP_READ;
      addr_q   <= '0;
      opnd_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (busy_q) begin
        busy_q   <= 1'b0;
        done_q   <= 1'b1;
        rdata_q  <= old_d;
        exists_q <= exists_d;
        ro_q     <= exists_d && csr_is_ro(addr_q) && (op_q != CSR_OP_READ);
      end else if (csr_en_i) begin
        busy_q <= 1'b1;
        op_q   <= csr_op_e'(csr_op_i);
        addr_q <= csr_addr_i;
        opnd_q <= csr_data_i;
      end
    end
  end

  // Trap and mret own the trap-state registers in the cycle they fire.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      st_mie_q  <= 1'b0;
      st_mpie_q <= 1'b0;
      mepc_q    <= '0;
      mcause_q  <= '0;
      mtval_q   <= '0;
    end else if (trap_i) begin
      st_mpie_q <= st_mie_q;
      st_mie_q  <= 1'b0;
      mepc_q    <= trap_epc_i & ALIGN_MASK;
      mcause_q  <= trap_cause_i;
      mtval_q   <= trap_tval_i;
    end else begin
      if (mret_i) begin
        st_mie_q  <= st_mpie_q;
        st_mpie_q <= 1'b1;
      end else if (commit_d && addr_q == CSR_MSTATUS) begin
        st_mie_q  <= new_d[MSTATUS_MIE_BIT];
        st_mpie_q <= new_d[MSTATUS_MPIE_BIT];
      end
      if (commit_d && addr_q == CSR_MEPC)   mepc_q   <= new_d & ALIGN_MASK;
      if (commit_d && addr_q == CSR_MCAUSE) mcause_q <= new_d;
      if (commit_d && addr_q == CSR_MTVAL)  mtval_q  <= new_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      mie_q      <= '0;
      mtvec_q    <= MTVEC_RESET;
      mscratch_q <= '0;
      msip_q     <= 1'b0;
      mtags_q    <= '0;
    end else if (commit_d) begin
      case (addr_q)
        CSR_MIE:      mie_q      <= new_d & MIE_WMASK;
        CSR_MTVEC:    mtvec_q    <= new_d & ALIGN_MASK;
        CSR_MSCRATCH: mscratch_q <= new_d;
        CSR_MIP:      msip_q     <= new_d[MIP_MSIP_BIT];
        MSR_MTAGS:    mtags_q    <= new_d[TAGS_WIDTH-1:0];
        default: ;
      endcase
    end
  end

`ifdef CSR_COUNTERS_EN
  csr_counter64 #(.W(XLEN)) u_mcycle (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (1'b1),
    .wr_lo_i (commit_d && addr_q == CSR_MCYCLE),
    .wr_hi_i (commit_d && addr_q == CSR_MCYCLEH),
    .wdata_i (new_d),
    .value_o (mcycle_w)
  );

  csr_counter64 #(.W(XLEN)) u_minstret (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .inc_i   (instret_i),
    .wr_lo_i (commit_d && addr_q == CSR_MINSTRET),
    .wr_hi_i (commit_d && addr_q == CSR_MINSTRETH),
    .wdata_i (new_d),
    .value_o (minstret_w)
  );
`else
  logic unused_instret;
  assign unused_instret = instret_i;
`endif

  assign csr_data_o    = rdata_q;
  assign csr_busy_o    = busy_q;
  assign csr_done_o    = done_q;
  assign csr_exists_o  = exists_q;
  assign csr_ro_o      = ro_q;
  assign mtvec_o       = mtvec_q;
  assign mepc_o        = mepc_q;
  assign irq_pending_o = st_mie_q && ((mip_w & mie_q) != '0);

endmodule
`default_nettype wire

// File: tb/tb_csr_file.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_csr_file: directed + random stimulus against a spec-level CSR model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_csr_file;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        csr_en_i = 1'b0;
  logic [1:0]  csr_op_i = 2'b00;
  logic [11:0] csr_addr_i = 12'h000;
  logic [31:0] csr_data_i = 32'h0;
  logic [31:0] csr_data_o;
  logic        csr_busy_o, csr_done_o, csr_exists_o, csr_ro_o;
  logic        trap_i = 1'b0;
  logic [31:0] trap_cause_i = 32'h0, trap_epc_i = 32'h0, trap_tval_i = 32'h0;
  logic        mret_i = 1'b0, instret_i = 1'b0, irq_ext_i = 1'b0, irq_timer_i = 1'b0;
  logic [31:0] mtvec_o, mepc_o;
  logic        irq_pending_o;

  int total = 0;
  int bad   = 0;

  csr_file dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .csr_en_i(csr_en_i), .csr_op_i(csr_op_i), .csr_addr_i(csr_addr_i),
    .csr_data_i(csr_data_i), .csr_data_o(csr_data_o), .csr_busy_o(csr_busy_o),
    .csr_done_o(csr_done_o), .csr_exists_o(csr_exists_o), .csr_ro_o(csr_ro_o),
    .trap_i(trap_i), .trap_cause_i(trap_cause_i), .trap_epc_i(trap_epc_i),
    .trap_tval_i(trap_tval_i), .mret_i(mret_i), .instret_i(instret_i),
    .irq_ext_i(irq_ext_i), .irq_timer_i(irq_timer_i),
    .mtvec_o(mtvec_o), .mepc_o(mepc_o), .irq_pending_o(irq_pending_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_mie_b = 0, m_mpie = 0, m_msip = 0;
  logic [31:0]     m_mie = 0, m_mtvec = 32'h100, m_mepc = 0, m_mcause = 0;
  logic [31:0]     m_mtval = 0, m_mscratch = 0, m_mtags = 0;
  longint unsigned m_cycle = 0, m_instret = 0;
  bit              m_busy = 0;
  logic [1:0]      p_op = 0;
  logic [11:0]     p_addr = 0;
  logic [31:0]     p_data = 0;
  bit              e_done = 0, e_ex = 0, e_ro = 0;
  logic [31:0]     e_data = 0;

  function automatic bit addr_ro(input logic [11:0] a);
    return (a >= 12'hC00) || (a == 12'h301);
  endfunction

  function automatic void model_read(input logic [11:0] a, output bit ex, output logic [31:0] v);
    ex = 1;
    v  = 0;
    case (a)
      12'h300: v = 32'h1800 | (m_mpie ? 32'h80 : 0) | (m_mie_b ? 32'h8 : 0);
      12'h301: v = 32'h4000_0100;
      12'h304: v = m_mie;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = m_mcause;
      12'h343: v = m_mtval;
      12'h344: v = (irq_ext_i ? 32'h800 : 0) | (irq_timer_i ? 32'h80 : 0) | (m_msip ? 32'h8 : 0);
      12'hF11, 12'hF14: v = 0;
      csr_file_pkg::MSR_MTAGS: v = m_mtags;
`ifdef CSR_COUNTERS_EN
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
`endif
      default: ex = 0;
    endcase
  endfunction

  bit              mb_ex, mb_wr;
  logic [31:0]     mb_old, mb_nv;
  longint unsigned nxt_cyc, nxt_ins;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mie_b = 0; m_mpie = 0; m_msip = 0; m_mie = 0; m_mtvec = 32'h100;
      m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0; m_mtags = 0;
      m_cycle = 0; m_instret = 0; m_busy = 0; e_done = 0;
    end else begin
      e_done  = 0;
      nxt_cyc = m_cycle + 1;
      nxt_ins = m_instret + (instret_i ? 1 : 0);
      if (m_busy) begin
        model_read(p_addr, mb_ex, mb_old);
        mb_wr = mb_ex && !addr_ro(p_addr) && (p_op != 2'b00);
        case (p_op)
          2'b01:   mb_nv = p_data;
          2'b10:   mb_nv = mb_old | p_data;
          2'b11:   mb_nv = mb_old & ~p_data;
          default: mb_nv = mb_old;
        endcase
        e_done = 1;
        e_data = mb_old;
        e_ex   = mb_ex;
        e_ro   = mb_ex && addr_ro(p_addr) && (p_op != 2'b00);
        if (mb_wr) begin
          case (p_addr)
            12'h300: if (!trap_i && !mret_i) begin m_mie_b = mb_nv[3]; m_mpie = mb_nv[7]; end
            12'h304: m_mie = mb_nv & 32'h888;
            12'h305: m_mtvec = mb_nv & ~32'h3;
            12'h340: m_mscratch = mb_nv;
            12'h341: if (!trap_i) m_mepc = mb_nv & ~32'h3;
            12'h342: if (!trap_i) m_mcause = mb_nv;
            12'h343: if (!trap_i) m_mtval = mb_nv;
            12'h344: m_msip = mb_nv[3];
            csr_file_pkg::MSR_MTAGS: m_mtags = mb_nv & 32'hFF;
            12'hB00: nxt_cyc = {m_cycle[63:32], mb_nv};
            12'hB80: nxt_cyc = {mb_nv, m_cycle[31:0]};
            12'hB02: nxt_ins = {m_instret[63:32], mb_nv};
            12'hB82: nxt_ins = {mb_nv, m_instret[31:0]};
            default: ;
          endcase
        end
        m_busy = 0;
      end else if (csr_en_i) begin
        p_op = csr_op_i; p_addr = csr_addr_i; p_data = csr_data_i;
        m_busy = 1;
      end
      m_cycle   = nxt_cyc;
      m_instret = nxt_ins;
      if (trap_i) begin
        m_mpie = m_mie_b; m_mie_b = 0;
        m_mepc = trap_epc_i & ~32'h3; m_mcause = trap_cause_i; m_mtval = trap_tval_i;
      end else if (mret_i) begin
        m_mie_b = m_mpie; m_mpie = 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [31:0] exp_mip;
  always @(negedge clk) begin
    exp_mip = (irq_ext_i ? 32'h800 : 0) | (irq_timer_i ? 32'h80 : 0) | (m_msip ? 32'h8 : 0);
    check("busy", csr_busy_o, m_busy);
    check("done", csr_done_o, e_done);
    if (e_done) begin
      check("data", csr_data_o, e_data);
      check("exists", csr_exists_o, e_ex);
      check("ro", csr_ro_o, e_ro);
    end
    check("mtvec_o", mtvec_o, m_mtvec);
    check("mepc_o", mepc_o, m_mepc);
    check("irq_pending", irq_pending_o, m_mie_b && ((exp_mip & m_mie) != 0));
  end

  // ---------------- directed helpers ----------------
  task automatic do_req(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d,
                        input bit tr, input logic [31:0] tepc, input logic [31:0] tcause,
                        output logic [31:0] rd, output logic ex, output logic ro, output int lat);
    int guard = 0;
    while (csr_busy_o && guard < 5) begin @(posedge clk); #1; guard++; end
    csr_en_i = 1; csr_op_i = op; csr_addr_i = a; csr_data_i = d;
    @(posedge clk); #1;
    csr_en_i = 0;
    lat = 1;
    if (tr) begin trap_i = 1; trap_epc_i = tepc; trap_cause_i = tcause; trap_tval_i = 0; end
    while (!csr_done_o && lat < 6) begin @(posedge clk); #1; lat++; trap_i = 0; end
    trap_i = 0;
    rd = csr_data_o; ex = csr_exists_o; ro = csr_ro_o;
  endtask

  task automatic pulse(input bit tr, input bit mr, input logic [31:0] cause, input logic [31:0] epc);
    trap_i = tr; mret_i = mr; trap_cause_i = cause; trap_epc_i = epc; trap_tval_i = 32'h0;
    @(posedge clk); #1;
    trap_i = 0; mret_i = 0;
  endtask

  logic [11:0] addr_tbl [22] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                 12'h342, 12'h343, 12'h344, 12'hF11, 12'hF14, 12'h7C0,
                                 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                                 12'hC02, 12'hC82, 12'h7FF, 12'h000};

  initial begin
    logic [31:0] rd;
    logic        ex, ro;
    int          lat;

    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;

    do_req(2'b00, 12'h305, 0, 0, 0, 0, rd, ex, ro, lat);
    check("reset_mtvec", rd, 32'h100);
    check("latency", lat, 2);
    do_req(2'b00, 12'h300, 0, 0, 0, 0, rd, ex, ro, lat);
    check("reset_mstatus", rd, 32'h1800);

    do_req(2'b01, 12'h340, 32'hDEADBEEF, 0, 0, 0, rd, ex, ro, lat);
    check("mscratch_w_old", rd, 32'h0);
    do_req(2'b10, 12'h340, 32'h10, 0, 0, 0, rd, ex, ro, lat);
    check("mscratch_s_old", rd, 32'hDEADBEEF);
    do_req(2'b11, 12'h340, 32'hF, 0, 0, 0, rd, ex, ro, lat);
    check("mscratch_c_old", rd, 32'hDEADBEFF);
    do_req(2'b00, 12'h340, 0, 0, 0, 0, rd, ex, ro, lat);
    check("mscratch_final", rd, 32'hDEADBEF0);

    do_req(2'b01, 12'h301, 0, 0, 0, 0, rd, ex, ro, lat);
    check("misa_ro", ro, 1'b1);
    check("misa_exists", ex, 1'b1);
    do_req(2'b00, 12'h301, 0, 0, 0, 0, rd, ex, ro, lat);
    check("misa_kept", rd, 32'h4000_0100);
    do_req(2'b00, 12'h7FF, 0, 0, 0, 0, rd, ex, ro, lat);
    check("none_exists", ex, 1'b0);
    check("none_data", rd, 32'h0);

    do_req(2'b01, 12'h300, 32'h8, 0, 0, 0, rd, ex, ro, lat);
    pulse(1, 0, 32'h8000000B, 32'h1237);
    do_req(2'b00, 12'h341, 0, 0, 0, 0, rd, ex, ro, lat);
    check("trap_mepc", rd, 32'h1234);
    do_req(2'b00, 12'h342, 0, 0, 0, 0, rd, ex, ro, lat);
    check("trap_mcause", rd, 32'h8000000B);
    do_req(2'b00, 12'h300, 0, 0, 0, 0, rd, ex, ro, lat);
    check("trap_mstatus", rd, 32'h1880);
    pulse(0, 1, 0, 0);
    do_req(2'b00, 12'h300, 0, 0, 0, 0, rd, ex, ro, lat);
    check("mret_mstatus", rd, 32'h1888);

    do_req(2'b01, 12'h341, 32'h500, 1, 32'h600, 32'h2, rd, ex, ro, lat);
    check("race_done_lat", lat, 2);
    check("race_old", rd, 32'h1234);
    do_req(2'b00, 12'h341, 0, 0, 0, 0, rd, ex, ro, lat);
    check("race_mepc", rd, 32'h600);

`ifdef CSR_COUNTERS_EN
    do_req(2'b01, 12'hB80, 32'hFFFFFFFF, 0, 0, 0, rd, ex, ro, lat);
    do_req(2'b01, 12'hB00, 32'hFFFFFFFF, 0, 0, 0, rd, ex, ro, lat);
    repeat (2) @(posedge clk);
    #1;
    do_req(2'b00, 12'hB80, 0, 0, 0, 0, rd, ex, ro, lat);
    check("mcycleh_wrap", rd, 32'h0);
    do_req(2'b01, 12'hB02, 32'h5, 0, 0, 0, rd, ex, ro, lat);
    do_req(2'b00, 12'hB02, 0, 0, 0, 0, rd, ex, ro, lat);
    check("minstret_hold", rd, 32'h5);
`else
    do_req(2'b00, 12'hB00, 0, 0, 0, 0, rd, ex, ro, lat);
    check("mcycle_absent", ex, 1'b0);
`endif

    for (int i = 0; i < 1500; i++) begin
      csr_en_i    = ($urandom_range(0, 1) == 1);
      csr_op_i    = 2'($urandom_range(0, 3));
      csr_addr_i  = ($urandom_range(0, 9) == 0) ? 12'($urandom) : addr_tbl[$urandom_range(0, 21)];
      csr_data_i  = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFFF : $urandom;
      trap_i      = ($urandom_range(0, 29) == 0);
      mret_i      = ($urandom_range(0, 29) == 0);
      trap_cause_i = $urandom; trap_epc_i = $urandom; trap_tval_i = $urandom;
      instret_i   = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 9) == 0) irq_ext_i = ~irq_ext_i;
      if ($urandom_range(0, 9) == 0) irq_timer_i = ~irq_timer_i;
      if (i == 800) begin
        csr_en_i = 1;
        @(posedge clk); #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        csr_en_i = 0;
      end
      @(posedge clk); #1;
    end
    csr_en_i = 0; trap_i = 0; mret_i = 0;
    repeat (4) @(posedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/csr_file.md
Name: csr_file

Overview:
Second-generation machine-mode CSR unit for the RV32 core. It replaces the plain RAM-backed CSR store with real per-register flops and three further capabilities:
- address decode with exists/read-only reporting;
- atomic read-modify-write operations (write/set/clear);
- hardware trap entry and mret state updates.
It also provides free-running cycle and retired-instruction counters. It sits beside the execute stage, which issues one request at a time and waits for done.

Parameters:
XLEN, 32, data width of every CSR and data port
HART_ID, 0, value returned by mhartid
VENDOR_ID, 0, value returned by mvendorid
MISA_VALUE, 32'h40000100, value returned by misa (RV32I)
MTVEC_RESET, 32'h00000100, reset value of mtvec
TAGS_WIDTH, 8, implemented low bits of custom mtags (upper bits read 0)

Ports:
clk_i  in  1  clock
rst_n_i  in  1  asynchronous active-low reset
csr_en_i  in  1  request strobe, accepted only while csr_busy_o=0
csr_op_i  in  2  00 read, 01 write, 10 set, 11 clear
csr_addr_i  in  12  CSR address
csr_data_i  in  XLEN  operand (rs1 or immediate)
csr_data_o  out  XLEN  old CSR value, valid while csr_done_o=1
csr_busy_o  out  1  request in flight
csr_done_o  out  1  one-cycle completion pulse
csr_exists_o  out  1  address implemented, valid with done
csr_ro_o  out  1  illegal write attempt (read-only target, op≠read), valid with done
trap_i  in  1  take trap this cycle
trap_cause_i  in  XLEN  mcause value
trap_epc_i  in  XLEN  faulting pc
trap_tval_i  in  XLEN  mtval value
mret_i  in  1  mret retiring this cycle
instret_i  in  1  one instruction retired this cycle
irq_ext_i, irq_timer_i  in  1 each  level interrupt lines
mtvec_o  out  XLEN  trap vector
mepc_o  out  XLEN  return pc
irq_pending_o  out  1  (mip & mie) nonzero and mstatus.MIE=1

Behaviour:
- Reset (async assert, sync release):
  - busy, done, exists, ro and csr_data_o = 0.
  - mstatus.MIE/MPIE = 0, mie = 0, mepc = 0, mcause = 0, mtval = 0, mscratch = 0, mtags = 0, counters = 0.
  - mtvec = MTVEC_RESET.
- Handshake:
  - Cycle N: csr_en_i with busy=0 latches addr, op and data; busy←1.
  - Cycle N+1: decode, read old value, write new value, done=1 with data/exists/ro; busy←0.
  - Latency is 2 cycles, so back-to-back requests are accepted every 2nd cycle.
  - csr_en_i while busy=1 is ignored.
- New value:
  - write: operand.
  - set: old | operand.
  - clear: old & ~operand.
  - A write commits only when exists=1 and the target is writable. Otherwise nothing changes, csr_data_o still returns the old value, and ro=1 if op≠read.
- Nonexistent address: exists=0, data=0, ro=0.
- Read-only set: mvendorid, mhartid, misa, and any addr[11:10]=11.
- Field write rules (WARL):
  - mstatus: only bit 3 (MIE) and bit 7 (MPIE) are writable; MPP bits [12:11] always read 11.
  - mtvec and mepc: bits [1:0] are forced to 0 (direct mode only).
  - mie: bits 3, 7, 11 writable.
  - mip: bit 11 = irq_ext_i and bit 7 = irq_timer_i (read-only); bit 3 (MSIP) writable.
  - mtags: only [TAGS_WIDTH-1:0] stored.
- Trap (trap_i=1):
  - mepc ← trap_epc_i & ~3, mcause ← trap_cause_i, mtval ← trap_tval_i.
  - MPIE ← MIE, MIE ← 0.
- mret (mret_i=1): MIE ← MPIE, MPIE ← 1.
- Simultaneous events:
  - trap_i and mret_i together: trap wins.
  - Trap or mret in the same cycle as a committing write to mstatus/mepc/mcause/mtval: hardware update wins, and the software write to that register is dropped. done and data still report normally.
  - Writes to other registers proceed.
- Counters (optional feature, below):
  - mcycle increments every cycle; minstret increments when instret_i=1. Both are 64-bit and wrap 2^64-1 → 0.
  - A software write to the lo or hi half takes precedence over that cycle's increment for the whole counter: the written half takes the new value, the other half holds.
- Reset mid-request: the request is abandoned and no done pulse follows.

Optional Feature:
CSR_COUNTERS_EN
- Defined: mcycle (0xB00), mcycleh (0xB80), minstret (0xB02), minstreth (0xB82) are implemented and writable. Read-only shadows cycle/cycleh/instret/instreth (0xC00/0xC80/0xC02/0xC82) are also implemented.
- Undefined: counters are not built, these addresses report exists=0, and instret_i is unused.

Decomposition:
- Shared header cpu/csrdefs.vh: all CSR address macros, including MSR_MTAGS and the counter addresses; op-code constants CSR_OP_READ/WRITE/SET/CLEAR; mstatus/mip/mie bit-position constants; WARL mask constants.
- One sub-module, csr_counter64: a 64-bit counter with increment enable and independent lo/hi write ports, instantiated twice.

Test Plan:
- Reset release → read mtvec returns 0x00000100, mstatus returns 0x00001800, done exactly 2 cycles after en.
- write mscratch 0xDEADBEEF; set 0x00000010; clear 0x0000000F → reads return old values; final mscratch = 0xDEADBEF0.
- write misa 0 → ro=1, exists=1, misa unchanged; read 0x7FF → exists=0, data=0.
- mstatus.MIE=1, trap_i with cause 0x8000000B and epc 0x1237 → mepc=0x1234, mcause=0x8000000B, MIE=0, MPIE=1. Then mret_i → MIE=1.
- Write mepc 0x500 in the same cycle as trap_i with epc 0x600 → mepc=0x600, done pulses, data returns the prior mepc.
- (CSR_COUNTERS_EN) write mcycle 0xFFFFFFFF and mcycleh 0xFFFFFFFF, wait 2 cycles → counter wrapped, mcycleh=0. Without the macro, read 0xB00 → exists=0.
